// File: rtl/gray_pkg.sv
// Shared definitions for the Gray source and the decoder side: default width,
// binary-to-Gray conversion and the debouncer level state.
package gray_pkg;

  localparam int GRAY_WIDTH     = 4;
  localparam int GRAY_MAX_WIDTH = 32;

  typedef enum logic {
    DB_LOW  = 1'b0,
    DB_HIGH = 1'b1
  } db_state_t;

  // Width-agnostic up to GRAY_MAX_WIDTH: zero-extend, convert, truncate.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Raw button conditioning: two-flop synchronizer, stable-level debouncer and
// a one-cycle press pulse on each accepted 0->1 change of the debounced level.
//
//   state   | meaning
//   DB_LOW  | debounced level is 0 (button released)
//   DB_HIGH | debounced level is 1 (button pressed)
module button_debouncer
  import gray_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  db_state_t     state;
  logic          sync_level;

  assign sync_level = sync[1];
  assign level      = (state == DB_HIGH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      state <= DB_LOW;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync_level == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // rise is registered alongside the level change so it lines up with db
        cnt   <= '0;
        state <= sync_level ? DB_HIGH : DB_LOW;
        rise  <= sync_level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gray_code_generator.sv
// Up/down Gray-code source: debounced inc/dec buttons or a fixed-rate auto
// step drive a binary counter; gray, bin, step and wrap are all registered.
module gray_code_generator
  import gray_pkg::*;
#(
  parameter int WIDTH           = GRAY_WIDTH,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int AUTO_PERIOD     = 27000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_inc,
  input  logic             btn_dec,
  input  logic             auto_en,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             step,
  output logic             wrap
);

  localparam int PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [PW-1:0]    PERIOD_LAST = PW'(AUTO_PERIOD - 1);
  localparam logic [WIDTH-1:0] BIN_MAX     = '1;

  logic             level_inc, level_dec;
  logic             rise_inc, rise_dec;
  logic             unused_levels;
  logic [PW-1:0]    period_cnt;
  logic             auto_tick;
  logic             count_up, count_down;
  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_inc),
    .level (level_inc),
    .rise  (rise_inc)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_dec),
    .level (level_dec),
    .rise  (rise_dec)
  );

  assign unused_levels = level_inc ^ level_dec;

  // Button events are dropped in auto mode; simultaneous inc+dec cancel out.
  always_comb begin
    auto_tick  = auto_en && (period_cnt == PERIOD_LAST);
    count_up   = auto_tick || (!auto_en && rise_inc && !rise_dec);
    count_down = !auto_en && rise_dec && !rise_inc;
    bin_next   = bin;
    wrap_next  = 1'b0;
    if (count_up) begin
      bin_next  = bin + WIDTH'(1);
      wrap_next = (bin == BIN_MAX);
    end else if (count_down) begin
      bin_next  = bin - WIDTH'(1);
      wrap_next = (bin == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_cnt <= '0;
      bin        <= '0;
      gray       <= '0;
      step       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      if (!auto_en || period_cnt == PERIOD_LAST) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + PW'(1);
      end
      bin  <= bin_next;
      gray <= WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_next)));
      step <= count_up || count_down;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_gray_code_generator.sv
// Directed + randomized bench for gray_code_generator with a reflected-Gray
// reference table and a modular-arithmetic count model.
module tb_gray_code_generator;

  localparam int W  = 4;
  localparam int DB = 4;
  localparam int AP = 3;
  localparam int N  = 1 << W;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         btn_inc = 1'b0;
  logic         btn_dec = 1'b0;
  logic         auto_en = 1'b0;
  logic [W-1:0] gray;
  logic [W-1:0] bin;
  logic         step;
  logic         wrap;

  int total = 0;
  int bad   = 0;
  int m_bin = 0;
  logic [W-1:0] gseq [N];

  always #5 clk = ~clk;

  gray_code_generator #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (DB),
    .AUTO_PERIOD     (AP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .auto_en (auto_en),
    .gray    (gray),
    .bin     (bin),
    .step    (step),
    .wrap    (wrap)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    auto_en = 1'b0;
    repeat (3) cyc();
    chk("reset_bin", bin, 0);
    chk("reset_gray", gray, 0);
    chk("reset_step", step, 0);
    rst_n = 1'b1;
    m_bin = 0;
  endtask

  task automatic idle(input string tag, input int n);
    int s;
    s = 0;
    repeat (n) begin
      cyc();
      if (step) s++;
    end
    chk(tag, s, 0);
    chk({tag, "_bin"}, bin, m_bin);
  endtask

  // One clean press held for 'hold' cycles; checks latency, value, wrap, one-bit change.
  task automatic press(input string tag, input bit up, input int hold);
    int nb, steps, wraps, lat;
    bit ew;
    logic [W-1:0] g_before;
    g_before = gray;
    nb    = up ? (m_bin + 1) % N : (m_bin + N - 1) % N;
    ew    = up ? (m_bin == N - 1) : (m_bin == 0);
    steps = 0;
    wraps = 0;
    lat   = -1;
    if (up) btn_inc = 1'b1; else btn_dec = 1'b1;
    for (int i = 1; i <= hold + 10; i++) begin
      cyc();
      if (wrap) wraps++;
      if (step) begin
        steps++;
        if (lat < 0) begin
          lat = i;
          chk({tag, "_bin"}, bin, nb);
          chk({tag, "_gray"}, gray, gseq[nb]);
          chk({tag, "_wrap"}, wrap, ew);
          chk({tag, "_onebit"}, $countones(gray ^ g_before), 1);
        end
      end
      if (i == hold) begin
        btn_inc = 1'b0;
        btn_dec = 1'b0;
      end
    end
    chk({tag, "_latency"}, lat, 2 + DB + 1);
    chk({tag, "_steps"}, steps, 1);
    chk({tag, "_wraps"}, wraps, ew ? 1 : 0);
    m_bin = nb;
  endtask

  task automatic glitch(input int len, input int gap, inout int steps);
    btn_inc = 1'b1;
    repeat (len) begin cyc(); if (step) steps++; end
    btn_inc = 1'b0;
    repeat (gap) begin cyc(); if (step) steps++; end
  endtask

  initial begin
    int lat, steps;
    bit exp_step;

    gseq[0] = '0;
    for (int k = 0; k < W; k++) begin
      for (int j = 0; j < (1 << k); j++) begin
        gseq[(1 << k) + j] = gseq[(1 << k) - 1 - j] | W'(1 << k);
      end
    end

    // 1: reset dominates a held button; release gives a step 7 cycles later
    rst_n   = 1'b0;
    btn_inc = 1'b1;
    repeat (4) begin
      cyc();
      chk("rst_hold_step", step, 0);
      chk("rst_hold_bin", bin, 0);
      chk("rst_hold_gray", gray, 0);
    end
    rst_n = 1'b1;
    lat   = -1;
    steps = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc();
      if (step) begin
        steps++;
        if (lat < 0) lat = i;
      end
    end
    chk("rst_release_latency", lat, 7);
    chk("rst_release_steps", steps, 1);
    btn_inc = 1'b0;
    m_bin   = 1;
    idle("rst_release_idle", 10);

    // 2: glitches shorter than the debounce window never register
    do_reset();
    steps = 0;
    repeat (3) glitch(3, 3, steps);
    repeat (3) glitch($urandom_range(1, 3), $urandom_range(1, 5), steps);
    repeat (8) begin cyc(); if (step) steps++; end
    chk("glitch_steps", steps, 0);
    chk("glitch_bin", bin, 0);
    press("glitch_accept", 1'b1, 4);

    // 3: full up sweep with wrap on the 16th press
    do_reset();
    for (int k = 0; k < N; k++) press("sweep", 1'b1, $urandom_range(4, 8));
    chk("sweep_final_bin", bin, 0);

    // 4: down wrap from zero
    do_reset();
    press("dec_wrap", 1'b0, $urandom_range(4, 7));
    chk("dec_wrap_gray", gray, 4'b1000);

    // 5: simultaneous presses cancel, then a random walk
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    idle("simul_held", 15);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    idle("simul_release", 10);
    repeat (10) press("walk", 1'($urandom_range(0, 1)), $urandom_range(4, 9));

    // 6: auto mode from bin = 5, button ignored, clean exit with button held
    do_reset();
    repeat (5) press("auto_setup", 1'b1, 5);
    chk("auto_setup_bin", bin, 5);
    auto_en = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      cyc();
      exp_step = (i % AP == 0);
      chk("auto_step", step, exp_step);
      if (exp_step) begin
        m_bin = (m_bin + 1) % N;
        chk("auto_bin", bin, m_bin);
        chk("auto_gray", gray, gseq[m_bin]);
      end
      if (i == 4) btn_inc = 1'b1;
      if (i == 21) auto_en = 1'b0;
    end
    idle("auto_off_held", 12);
    btn_inc = 1'b0;
    idle("auto_off_release", 10);
    chk("auto_final_bin", bin, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
